// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the board-level reset controller and the reset sequencer.
// The sequencer takes the slave side. The master side drives restart, mask and acknowledges.
interface reset_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic              restart;
    logic [NUM_CH-1:0] ch_wait_mask;
    logic [NUM_CH-1:0] ch_done;
    logic [NUM_CH-1:0] ch_rst_out;
    logic [3:0]        cur_ch;
    logic              seq_done;
    logic              timeout_err;

    modport master (
        output restart, ch_wait_mask, ch_done,
        input  ch_rst_out, cur_ch, seq_done, timeout_err
    );

    modport slave (
        input  restart, ch_wait_mask, ch_done,
        output ch_rst_out, cur_ch, seq_done, timeout_err
    );
endinterface

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: releases subsystem resets one channel at a time in ascending order,
// optionally waiting for a per-channel acknowledge, with timeout detection and a restart input.
//
// state    | meaning
// ---------+------------------------------------------------------------
// HOLD     | counting STAGE_DLY cycles before releasing channel cur_ch
// WAIT_ACK | channel cur_ch released, waiting for its synchronized ack
// DONE     | every channel released and acknowledged
// ERROR    | ack of channel cur_ch timed out, all resets re-asserted
module reset_sequencer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16,
    parameter int STAGE_DLY    = 100,
    parameter int DONE_TIMEOUT = 65535,
    parameter int SYNC_STAGES  = 2
) (
    input logic               clk,
    input logic               rst,
    reset_sequencer_if.slave  bus
);
    localparam int               STAGE_EFF = (STAGE_DLY < 1) ? 1 : STAGE_DLY;
    localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(STAGE_EFF - 1);
    localparam logic [CNT_W-1:0] ACK_TC    = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [3:0]       LAST_CH   = 4'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT_ACK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [3:0]        cur_q, cur_nxt;
    logic [NUM_CH-1:0] ch_rst_q, ch_rst_nxt;
    logic              seq_done_q, seq_done_nxt;
    logic              err_q, err_nxt;

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0] sdone;
    logic [NUM_CH-1:0] mask_sh;
    logic [NUM_CH-1:0] sdone_sh;
    logic [NUM_CH-1:0] cur_bit;
    logic              mask_cur;
    logic              sdone_cur;
    logic              last_ch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ch_done};
        end
    end

    assign sdone = sync_q[SYNC_STAGES-1];

    // Shifting instead of indexing keeps the 4-bit channel number legal for any NUM_CH.
    assign mask_sh   = bus.ch_wait_mask >> cur_q;
    assign sdone_sh  = sdone >> cur_q;
    assign mask_cur  = mask_sh[0];
    assign sdone_cur = sdone_sh[0];
    assign cur_bit   = NUM_CH'(1) << cur_q;
    assign last_ch   = (cur_q == LAST_CH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            cur_q      <= '0;
            ch_rst_q   <= '1;
            seq_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            cur_q      <= cur_nxt;
            ch_rst_q   <= ch_rst_nxt;
            seq_done_q <= seq_done_nxt;
            err_q      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        cur_nxt      = cur_q;
        ch_rst_nxt   = ch_rst_q;
        seq_done_nxt = seq_done_q;
        err_nxt      = err_q;
        if (bus.restart) begin
            state_nxt    = S_HOLD;
            cnt_nxt      = '0;
            cur_nxt      = '0;
            ch_rst_nxt   = '1;
            seq_done_nxt = 1'b0;
            err_nxt      = 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == HOLD_TC) begin
                        cnt_nxt    = '0;
                        ch_rst_nxt = ch_rst_q & ~cur_bit;
                        if (mask_cur) begin
                            state_nxt = S_WAIT_ACK;
                        end else if (last_ch) begin
                            state_nxt    = S_DONE;
                            seq_done_nxt = 1'b1;
                            ch_rst_nxt   = '0;
                        end else begin
                            cur_nxt = cur_q + 4'd1;
                        end
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    // An ack arriving on the terminal-count cycle still counts as in time.
                    if (sdone_cur) begin
                        cnt_nxt = '0;
                        if (last_ch) begin
                            state_nxt    = S_DONE;
                            seq_done_nxt = 1'b1;
                            ch_rst_nxt   = '0;
                        end else begin
                            state_nxt = S_HOLD;
                            cur_nxt   = cur_q + 4'd1;
                        end
                    end else if (cnt_q == ACK_TC) begin
                        state_nxt  = S_ERROR;
                        ch_rst_nxt = '1;
                        err_nxt    = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    ch_rst_nxt   = '0;
                    seq_done_nxt = 1'b1;
                end
                S_ERROR: begin
                    ch_rst_nxt = '1;
                    err_nxt    = 1'b1;
                end
                default: begin
                    state_nxt = S_HOLD;
                end
            endcase
        end
    end

    assign bus.ch_rst_out  = ch_rst_q;
    assign bus.cur_ch      = cur_q;
    assign bus.seq_done    = seq_done_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random mask/ack timing, checked every edge
// against a model that derives release, ack, done and timeout edges arithmetically.
module tb_reset_sequencer;
    localparam int NUM_CH       = 4;
    localparam int CNT_W        = 16;
    localparam int STAGE_DLY    = 8;
    localparam int DONE_TIMEOUT = 32;
    localparam int SYNC_STAGES  = 2;
    localparam int NEVER        = 1 << 28;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic rst    = 1'b0;

    reset_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

    reset_sequencer #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .STAGE_DLY   (STAGE_DLY),
        .DONE_TIMEOUT(DONE_TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int base     = 0;
    int restart_at  = NEVER;
    int restart_end = NEVER;
    int done_edge, err_edge, err_ch;
    int d_rel[NUM_CH];
    int d_abs[NUM_CH];
    int rel[NUM_CH];
    int fin[NUM_CH];
    logic [NUM_CH-1:0] mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, obs, exp);
        end
    endtask

    // Walk the channels in order: release STAGE_DLY edges after the previous channel finished,
    // masked channels finish when the synchronized ack is seen or fail at the timeout edge.
    task automatic plan(input bit sync_cleared);
        int t, r, a, dd;
        t = base;
        done_edge = NEVER;
        err_edge  = NEVER;
        err_ch    = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            rel[i] = NEVER;
            fin[i] = NEVER;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            r = t + STAGE_DLY;
            rel[i] = r;
            if (mask[i]) begin
                dd = d_abs[i];
                if (sync_cleared && dd < base + 1) dd = base + 1;
                a = (dd + SYNC_STAGES > r + 1) ? dd + SYNC_STAGES : r + 1;
                if (a > r + DONE_TIMEOUT) begin
                    err_edge = r + DONE_TIMEOUT;
                    err_ch   = i;
                    return;
                end
                fin[i] = a;
            end else begin
                fin[i] = r;
            end
            t = fin[i];
        end
        done_edge = t;
    endtask

    task automatic check_now();
        logic [NUM_CH-1:0] er;
        int ec, nf;
        bit ed, et;
        if (edge_n >= err_edge) begin
            er = '1; ec = err_ch; ed = 1'b0; et = 1'b1;
        end else begin
            nf = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                er[i] = !(edge_n >= rel[i]);
                if (fin[i] <= edge_n) nf++;
            end
            ec = (nf > NUM_CH - 1) ? NUM_CH - 1 : nf;
            ed = (edge_n >= done_edge);
            et = 1'b0;
        end
        chk("ch_rst_out",  32'(bus.ch_rst_out),  32'(er));
        chk("cur_ch",      32'(bus.cur_ch),      32'(ec));
        chk("seq_done",    32'(bus.seq_done),    32'(ed));
        chk("timeout_err", 32'(bus.timeout_err), 32'(et));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rst_out"}, 32'(bus.ch_rst_out), 32'hF);
        chk({tag, "_cur"},     32'(bus.cur_ch),     32'h0);
        chk({tag, "_done"},    32'(bus.seq_done),   32'h0);
        chk({tag, "_err"},     32'(bus.timeout_err), 32'h0);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < NUM_CH; i++) bus.ch_done[i] = (edge_n + 1 >= d_abs[i]);
            bus.restart = (edge_n + 1 >= restart_at) && (edge_n + 1 <= restart_end);
            @(posedge clk);
            edge_n++;
            if (edge_n >= restart_at && edge_n <= restart_end) begin
                base = edge_n;
                plan(1'b0);
            end
            #1;
            check_now();
        end
        bus.restart = 1'b0;
    endtask

    task automatic start(input logic [NUM_CH-1:0] m);
        mask = m;
        bus.ch_wait_mask = m;
        bus.restart = 1'b0;
        bus.ch_done = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("in_rst");
        @(negedge clk);
        rst = 1'b1;
        base = edge_n;
        for (int i = 0; i < NUM_CH; i++) d_abs[i] = (d_rel[i] >= NEVER) ? NEVER : base + d_rel[i];
        restart_at  = NEVER;
        restart_end = NEVER;
        plan(1'b1);
    endtask

    initial begin
        bus.restart = 1'b0;
        bus.ch_wait_mask = '0;
        bus.ch_done = '0;

        // Plain release, no acknowledges needed.
        d_rel = '{NEVER, NEVER, NEVER, NEVER};
        start(4'b0000);
        run(8);
        chk("s1_edge8", 32'(bus.ch_rst_out), 32'hE);
        run(24);
        chk("s1_edge32_done", 32'(bus.seq_done), 32'h1);
        run(10);

        // Channel 1 waits for its ack; a later ack drop is ignored.
        d_rel = '{NEVER, 20, NEVER, NEVER};
        start(4'b0010);
        run(38);
        chk("s2_edge38_done", 32'(bus.seq_done), 32'h1);
        d_abs[1] = NEVER;
        run(20);

        // Ack never arrives: error at edge 40, then stable.
        d_rel = '{NEVER, NEVER, NEVER, NEVER};
        start(4'b0001);
        run(40);
        chk("s3_edge40_err", 32'(bus.timeout_err), 32'h1);
        run(100);

        // Restart during the sequence, then restart out of ERROR.
        start(4'b0000);
        restart_at = base + 19; restart_end = base + 19;
        run(60);
        start(4'b0001);
        run(45);
        restart_at = edge_n + 2; restart_end = edge_n + 2;
        mask = 4'b0000; bus.ch_wait_mask = 4'b0000;
        run(45);

        // Restart held high for several edges.
        start(4'b0000);
        restart_at = edge_n + 5; restart_end = edge_n + 9;
        run(50);

        // Asynchronous reset with the clock stopped, then a clean rerun.
        start(4'b0000);
        run(13);
        clk_en = 1'b0;
        #2 rst = 1'b0;
        #3 chk_reset_vals("async_rst");
        #4 rst = 1'b1;
        base = edge_n;
        plan(1'b1);
        #3 clk_en = 1'b1;
        run(40);

        // Ack one edge before, exactly at, and one edge after the timeout terminal count.
        for (int v = 37; v <= 39; v++) begin
            d_rel = '{v, NEVER, NEVER, NEVER};
            start(4'b0001);
            run(60);
        end

        // Random masks and ack timing, with occasional restarts.
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NUM_CH; i++)
                d_rel[i] = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(1, 170));
            start(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                restart_at  = base + int'($urandom_range(3, 150));
                restart_end = restart_at + int'($urandom_range(0, 2));
            end
            run(190);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
